// File: rtl/adf4350_spi_sched.sv
// Shares one 32-bit serial shifter between the RF and LO ADF4350 synthesizers (round-robin),
// and tracks VCO settling per channel after each R0 write. Optional feature: LOCK_DETECT_EN.
module adf4350_spi_sched #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned LE_CYCLES     = 8,
  parameter int unsigned SETTLE_CYCLES = 8000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RF_REQ,
  input  logic [31:0] RF_DATA,
  output logic        RF_ACK,
  input  logic        LO_REQ,
  input  logic [31:0] LO_DATA,
  output logic        LO_ACK,
  output logic        D_CLK,
  output logic        D_OUT,
  output logic        D_LE,
  output logic        LO_D_CLK,
  output logic        LO_D_OUT,
  output logic        LO_D_LE,
  output logic        RF_SETTLED,
  output logic        LO_SETTLED,
`ifdef LOCK_DETECT_EN
  input  logic        RF_LD,
  input  logic        LO_LD,
`endif
  output logic        BUSY
);

  localparam int unsigned PhMax = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam logic [PhW-1:0] DivLast = PhW'(CLK_DIV - 1);
  localparam logic [PhW-1:0] LeLast  = PhW'(LE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StTail, StLe} state_t;

  state_t                  state_q, state_d;
  logic [PhW-1:0]          phase_q, phase_d;
  logic [5:0]              bit_q, bit_d;
  logic [31:0]             sr_q, sr_d;
  logic                    sel_q, sel_d;    // 0 = RF, 1 = LO
  logic                    last_q, last_d;  // channel served most recently
  logic                    r0_q, r0_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]              done_q, done_d;
  logic                    grant_lo;
  logic [1:0]              ld_ok;

  // LO wins only if RF is idle or RF was served last.
  assign grant_lo = LO_REQ && (!RF_REQ || !last_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sel_d   = sel_q;
    last_d  = last_q;
    r0_d    = r0_q;
    ack_d   = 2'b00;
    unique case (state_q)
      StIdle: begin
        // No re-grant on the ACK cycle: leaves a one-cycle gap between words.
        if ((RF_REQ || LO_REQ) && ack_q == 2'b00) begin
          state_d = StShiftLo;
          phase_d = '0;
          bit_d   = '0;
          sel_d   = grant_lo;
          last_d  = grant_lo;
          sr_d    = grant_lo ? LO_DATA : RF_DATA;
          r0_d    = grant_lo ? (LO_DATA[2:0] == 3'b000) : (RF_DATA[2:0] == 3'b000);
        end
      end
      StShiftLo: begin
        if (phase_q == DivLast) begin
          phase_d = '0;
          state_d = StShiftHi;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StShiftHi: begin
        if (phase_q == DivLast) begin
          phase_d = '0;
          sr_d    = {sr_q[30:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 6'd31) ? StTail : StShiftLo;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StTail: begin
        if (phase_q == DivLast) begin
          phase_d = '0;
          state_d = StLe;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StLe: begin
        if (phase_q == LeLast) begin
          phase_d      = '0;
          state_d      = StIdle;
          ack_d[sel_q] = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    for (int c = 0; c < 2; c++) begin
      cnt_d[c]  = cnt_q[c];
      done_d[c] = done_q[c];
      if (ack_d[c] && r0_q) begin
        cnt_d[c]  = CNT_W'(SETTLE_CYCLES);
        done_d[c] = 1'b1;
      end else if (cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      r0_q    <= 1'b0;
      ack_q   <= 2'b00;
      cnt_q   <= '0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      r0_q    <= r0_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef LOCK_DETECT_EN
  logic [1:0] rf_ld_q, lo_ld_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_ld_q <= 2'b00;
      lo_ld_q <= 2'b00;
    end else begin
      rf_ld_q <= {rf_ld_q[0], RF_LD};
      lo_ld_q <= {lo_ld_q[0], LO_LD};
    end
  end

  assign ld_ok = {lo_ld_q[1], rf_ld_q[1]};
`else
  assign ld_ok = 2'b11;
`endif

  logic pin_clk, pin_out, pin_le;

  assign pin_clk = (state_q == StShiftHi);
  assign pin_out = ((state_q == StShiftLo) || (state_q == StShiftHi)) && sr_q[31];
  assign pin_le  = (state_q == StLe);

  assign D_CLK      = pin_clk && !sel_q;
  assign D_OUT      = pin_out && !sel_q;
  assign D_LE       = pin_le  && !sel_q;
  assign LO_D_CLK   = pin_clk && sel_q;
  assign LO_D_OUT   = pin_out && sel_q;
  assign LO_D_LE    = pin_le  && sel_q;
  assign RF_ACK     = ack_q[0];
  assign LO_ACK     = ack_q[1];
  assign BUSY       = (state_q != StIdle);
  assign RF_SETTLED = done_q[0] && (cnt_q[0] == '0) && ld_ok[0];
  assign LO_SETTLED = done_q[1] && (cnt_q[1] == '0) && ld_ok[1];

endmodule

// File: tb/tb_adf4350_spi_sched.sv
// Bench for adf4350_spi_sched: per-cycle behavioural model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_adf4350_spi_sched;
  localparam int D     = 4;
  localparam int L     = 8;
  localparam int S     = 8000;
  localparam int NBITS = 32;
  localparam int ACK_K = 1 + 2 * D * NBITS + D + L;  // 269

  logic        CLK = 1'b0, RST = 1'b1;
  logic        RF_REQ = 1'b0, LO_REQ = 1'b0;
  logic [31:0] RF_DATA = '0, LO_DATA = '0;
  logic        RF_ACK, LO_ACK, D_CLK, D_OUT, D_LE, LO_D_CLK, LO_D_OUT, LO_D_LE;
  logic        RF_SETTLED, LO_SETTLED, BUSY;
`ifdef LOCK_DETECT_EN
  logic        RF_LD = 1'b1, LO_LD = 1'b1;
`endif

  adf4350_spi_sched dut (
    .CLK(CLK), .RST(RST),
    .RF_REQ(RF_REQ), .RF_DATA(RF_DATA), .RF_ACK(RF_ACK),
    .LO_REQ(LO_REQ), .LO_DATA(LO_DATA), .LO_ACK(LO_ACK),
    .D_CLK(D_CLK), .D_OUT(D_OUT), .D_LE(D_LE),
    .LO_D_CLK(LO_D_CLK), .LO_D_OUT(LO_D_OUT), .LO_D_LE(LO_D_LE),
    .RF_SETTLED(RF_SETTLED), .LO_SETTLED(LO_SETTLED),
`ifdef LOCK_DETECT_EN
    .RF_LD(RF_LD), .LO_LD(LO_LD),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_chk = 0, n_pass = 0;
  int last_ack = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, exp);
  endtask

  function automatic logic [10:0] outs();
    return {RF_ACK, LO_ACK, D_CLK, D_OUT, D_LE, LO_D_CLK, LO_D_OUT, LO_D_LE,
            RF_SETTLED, LO_SETTLED, BUSY};
  endfunction

  // Model: a transfer is described by its grant cycle, channel and word; every output in cycle
  // grant+k follows from k by arithmetic on the serial frame timing.
  bit          m_busy = 0, m_ch = 0, m_last = 1;
  logic [31:0] m_word = '0;
  int          m_g = 0;
  bit          m_have[2];
  int          m_r0[2];
  bit          ldp1[2], ldp2[2];

  always @(negedge CLK) begin
    logic [10:0] e;
    int k;
    bit ack_now, pc, po, pl, s;
    e = '0; ack_now = 0; pc = 0; po = 0; pl = 0;
    if (RST) begin
      m_busy = 0; m_last = 1;
      for (int c = 0; c < 2; c++) begin m_have[c] = 0; ldp1[c] = 0; ldp2[c] = 0; end
    end else begin
      if (m_busy) begin
        k = cyc - m_g;
        if (k >= 1 && k <= 2 * D * NBITS) begin
          pc = ((k - 1) % (2 * D)) >= D;
          po = m_word[31 - (k - 1) / (2 * D)];
        end
        pl = (k > 2 * D * NBITS + D) && (k < ACK_K);
        e[0] = (k < ACK_K);
        if (m_ch) e[5:3] = {pc, po, pl}; else e[8:6] = {pc, po, pl};
        if (k == ACK_K) begin
          ack_now = 1; m_busy = 0;
          if (m_ch) e[9] = 1'b1; else e[10] = 1'b1;
          if (m_word[2:0] == 3'b000) begin m_have[m_ch] = 1; m_r0[m_ch] = cyc; end
        end
      end
      for (int c = 0; c < 2; c++) begin
        s = m_have[c] && (cyc - m_r0[c] >= S);
`ifdef LOCK_DETECT_EN
        s = s && ldp2[c];
`endif
        e[2 - c] = s;
      end
`ifdef LOCK_DETECT_EN
      ldp2[0] = ldp1[0]; ldp2[1] = ldp1[1];
      ldp1[0] = RF_LD;   ldp1[1] = LO_LD;
`endif
    end
    check("outputs", {53'd0, outs()}, {53'd0, e});
    if (!RST && !m_busy && !ack_now && (RF_REQ || LO_REQ)) begin
      m_ch   = LO_REQ && (!RF_REQ || !m_last);
      m_last = m_ch;
      m_word = m_ch ? LO_DATA : RF_DATA;
      m_g    = cyc;
      m_busy = 1;
    end
  end

  // One word on one channel; returns ACK latency, received word, first D_CLK rise and D_LE cycle.
  task automatic xfer(input bit ch, input logic [31:0] w, input int chg_at,
                      input logic [31:0] chg_w, output int ack_at, output logic [31:0] rx,
                      output int fc, output int fl, output bit oth);
    int s;
    bit pclk, c_clk, c_out, c_le, c_ack, o_any;
    ack_at = -1; rx = '0; fc = -1; fl = -1; oth = 0; pclk = 0;
    @(posedge CLK); #1;
    if (ch) begin LO_DATA = w; LO_REQ = 1; end else begin RF_DATA = w; RF_REQ = 1; end
    s = cyc;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      if (cyc - s == chg_at) begin
        if (ch) LO_DATA = chg_w; else RF_DATA = chg_w;
      end
      c_clk = ch ? LO_D_CLK : D_CLK;
      c_out = ch ? LO_D_OUT : D_OUT;
      c_le  = ch ? LO_D_LE  : D_LE;
      c_ack = ch ? LO_ACK   : RF_ACK;
      o_any = ch ? (D_CLK | D_OUT | D_LE | RF_ACK) : (LO_D_CLK | LO_D_OUT | LO_D_LE | LO_ACK);
      if (o_any) oth = 1;
      if (c_clk && !pclk) begin
        rx = {rx[30:0], c_out};
        if (fc < 0) fc = cyc - s;
      end
      if (c_le && fl < 0) fl = cyc - s;
      pclk = c_clk;
      if (c_ack) begin
        ack_at = cyc - s; last_ack = cyc;
        if (ch) LO_REQ = 0; else RF_REQ = 0;
        break;
      end
    end
    if (ack_at < 0) begin RF_REQ = 0; LO_REQ = 0; end
  endtask

  task automatic wait_settled(input bit ch, input int from, input string name);
    int t;
    t = -1;
    for (int i = 0; i < S + 200; i++) begin
      @(posedge CLK); #1;
      if (ch ? LO_SETTLED : RF_SETTLED) begin t = cyc - from; break; end
    end
    check(name, t, S);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[2:0] = 3'b000;
    return w;
  endfunction

  initial begin
    int a, fc, fl, s, nack, lo_start, r0c;
    int ack_c[3];
    bit ack_ch[3];
    logic [31:0] rx;
    bit oth;

    repeat (3) @(posedge CLK);
    check("reset_outputs", {53'd0, outs()}, 64'd0);
    #1 RST = 0;

    // Simultaneous requests after reset: RF, LO, RF.
    @(posedge CLK); #1;
    RF_DATA = 32'h1234_5671; LO_DATA = 32'h0BAD_F00D; RF_REQ = 1; LO_REQ = 1;
    s = cyc; nack = 0; lo_start = -1;
    for (int i = 0; i < 1000 && nack < 3; i++) begin
      @(posedge CLK); #1;
      if (nack == 1 && BUSY && lo_start < 0) lo_start = cyc - s;
      if (RF_ACK || LO_ACK) begin
        ack_ch[nack] = LO_ACK; ack_c[nack] = cyc - s; nack++;
        if (nack == 3) begin RF_REQ = 0; LO_REQ = 0; end
      end
    end
    RF_REQ = 0; LO_REQ = 0;
    check("arb_ack_count", nack, 3);
    if (nack == 3) begin
      check("arb_first", {ack_ch[0], 31'd0, ack_c[0]}, {1'b0, 31'd0, 32'd269});
      check("arb_second", {ack_ch[1], 31'd0, ack_c[1]}, {1'b1, 31'd0, 32'd539});
      check("arb_third", {ack_ch[2], 31'd0, ack_c[2]}, {1'b0, 31'd0, 32'd809});
    end
    check("lo_start", lo_start, 271);

    // Single RF word, frame timing.
    xfer(0, 32'hA5A5_0000, -1, '0, a, rx, fc, fl, oth);
    check("rf_ack_cycle", a, 269);
    check("rf_word", rx, 32'hA5A5_0000);
    check("rf_first_clk", fc, 5);
    check("rf_first_le", fl, 261);
    check("lo_pins_quiet", oth, 0);

    // DATA changed after grant is ignored.
    xfer(0, 32'h0000_0005, 10, 32'hFFFF_FFFF, a, rx, fc, fl, oth);
    check("latched_word", rx, 32'h0000_0005);
    check("latched_ack", a, 269);

    // LO settle tracking.
    xfer(1, 32'h0040_0000, -1, '0, a, rx, fc, fl, oth);
    r0c = last_ack;
    check("lo_unsettled_on_ack", LO_SETTLED, 0);
    wait_settled(1, r0c, "lo_settle_time");
    xfer(1, 32'h0040_0000, -1, '0, a, rx, fc, fl, oth);
    repeat (2000) @(posedge CLK);
    #1;
    check("lo_counting", LO_SETTLED, 0);
    xfer(1, 32'h0040_0000, -1, '0, a, rx, fc, fl, oth);
    r0c = last_ack;
    wait_settled(1, r0c, "lo_restart_time");
    xfer(1, 32'h0800_8011, -1, '0, a, rx, fc, fl, oth);
    check("lo_r1_keeps_settled", LO_SETTLED, 1);

    // Reset during bit 17.
    @(posedge CLK); #1;
    RF_DATA = 32'h0000_0002; RF_REQ = 1; s = cyc;
    while (cyc - s < 130) begin @(posedge CLK); #1; end
    RST = 1;
    #1;
    check("reset_mid_outputs", {53'd0, outs()}, 64'd0);
    RF_REQ = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    xfer(0, 32'h8000_0003, -1, '0, a, rx, fc, fl, oth);
    check("post_reset_ack", a, 269);
    check("post_reset_word", rx, 32'h8000_0003);

    // Random requests, drops and data churn against the model.
    for (int i = 0; i < 6000; i++) begin
      @(posedge CLK); #1;
      if (RF_ACK) RF_REQ = 0;
      else if (!RF_REQ) begin if ($urandom_range(0, 39) == 0) RF_REQ = 1; end
      else if ($urandom_range(0, 299) == 0) RF_REQ = 0;
      if (LO_ACK) LO_REQ = 0;
      else if (!LO_REQ) begin if ($urandom_range(0, 39) == 0) LO_REQ = 1; end
      else if ($urandom_range(0, 299) == 0) LO_REQ = 0;
      if ($urandom_range(0, 3) == 0) RF_DATA = rnd_word();
      if ($urandom_range(0, 3) == 0) LO_DATA = rnd_word();
    end
    RF_REQ = 0; LO_REQ = 0;
    repeat (300) @(posedge CLK);
    #1;
    check("drained", BUSY, 0);

`ifdef LOCK_DETECT_EN
    RF_LD = 0;
    xfer(0, 32'h0058_0000, -1, '0, a, rx, fc, fl, oth);
    repeat (S + 10) @(posedge CLK);
    #1;
    check("rf_no_lock", RF_SETTLED, 0);
    RF_LD = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("rf_lock", RF_SETTLED, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
